// File: rtl/matrix_uart_printer_pkg.sv
// Shared definitions for the matrix UART printer: FSM encodings, ASCII
// constants and small helpers used by the printer and its serializer.
package matrix_uart_printer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT,
        CONV,
        SEND_DIG,
        SEND_SEP,
        SEND_EOL_CR,
        SEND_EOL_LF,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int MAX_DIM    = 5;
    localparam int NUM_DIGITS = 5;

    // Decimal weight of digit position pos, most significant first.
    function automatic logic [15:0] place_value(input logic [2:0] pos);
        case (pos)
            3'd0:    return 16'd10000;
            3'd1:    return 16'd1000;
            3'd2:    return 16'd100;
            3'd3:    return 16'd10;
            default: return 16'd1;
        endcase
    endfunction

    function automatic logic dim_legal(input logic [31:0] d);
        return (d != 32'd0) && (d <= 32'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_uart_printer_uart_tx_byte.sv
// 8N1 byte serializer. Idle line is high; the last stop-bit cycle doubles as
// the idle/accept cycle so a waiting byte starts with no gap between frames.
module uart_tx_byte
    import matrix_uart_printer_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx;

    assign o_ready = (state == TX_IDLE);
    assign o_tx    = tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (i_valid) begin
                        shreg <= i_data;
                        tx    <= 1'b0;
                        cnt   <= '0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    // One cycle short: the idle cycle completes the stop bit.
                    if (cnt == STOP_LAST) begin
                        cnt   <= '0;
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/matrix_uart_printer.sv
// Reads an m x n matrix row-major from storage and prints each element as
// unsigned decimal text over a UART, space-separated with CR LF per row.
module matrix_uart_printer
    import matrix_uart_printer_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_base_addr,
    input  logic [31:0] i_m,
    input  logic [31:0] i_n,
    output logic [7:0]  o_rd_addr,
    input  logic [31:0] i_rdata,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic        o_done,
    output state_t      o_state
);

    state_t      state;
    logic [2:0]  m_q, n_q, row, col;
    logic [7:0]  rd_addr;
    logic [15:0] value;
    logic [3:0]  digits [NUM_DIGITS];
    logic [3:0]  dig_cnt;
    logic [2:0]  pos, first, dig_idx;
    logic        started;
    logic        lf_sent;
    logic        busy, done;

    // Byte handshake: tx_valid rises with a byte and stays high until a cycle
    // where tx_ready is also high; that cycle is the transfer.
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;

    logic unused_rdata_hi;
    assign unused_rdata_hi = ^i_rdata[31:16];

    assign o_rd_addr = rd_addr;
    assign o_busy    = busy;
    assign o_done    = done;
    assign o_state   = state;

    always_comb begin
        tx_byte = ASCII_SPACE;
        case (state)
            SEND_DIG:    tx_byte = ASCII_ZERO + {4'd0, digits[dig_idx]};
            SEND_EOL_CR: tx_byte = ASCII_CR;
            SEND_EOL_LF: tx_byte = ASCII_LF;
            default:     tx_byte = ASCII_SPACE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            m_q      <= '0;
            n_q      <= '0;
            row      <= '0;
            col      <= '0;
            rd_addr  <= '0;
            value    <= '0;
            dig_cnt  <= '0;
            pos      <= '0;
            first    <= '0;
            dig_idx  <= '0;
            started  <= 1'b0;
            lf_sent  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (i_start) begin
                        if (dim_legal(i_m) && dim_legal(i_n)) begin
                            m_q     <= i_m[2:0];
                            n_q     <= i_n[2:0];
                            row     <= '0;
                            col     <= '0;
                            rd_addr <= i_base_addr;
                            busy    <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    value   <= i_rdata[15:0];
                    pos     <= '0;
                    dig_cnt <= '0;
                    started <= 1'b0;
                    first   <= 3'd4;
                    state   <= CONV;
                end
                CONV: begin
                    // One subtraction per cycle; a failed compare closes the digit.
                    if (value >= place_value(pos)) begin
                        value   <= value - place_value(pos);
                        dig_cnt <= dig_cnt + 4'd1;
                    end else begin
                        digits[pos] <= dig_cnt;
                        dig_cnt     <= '0;
                        if (dig_cnt != 4'd0 && !started) begin
                            started <= 1'b1;
                            first   <= pos;
                        end
                        if (pos == 3'd4) begin
                            dig_idx  <= started ? first : 3'd4;
                            tx_valid <= 1'b1;
                            state    <= SEND_DIG;
                        end else begin
                            pos <= pos + 3'd1;
                        end
                    end
                end
                SEND_DIG: begin
                    if (tx_valid && tx_ready) begin
                        if (dig_idx == 3'd4)
                            state <= (col == n_q - 3'd1) ? SEND_EOL_CR : SEND_SEP;
                        else
                            dig_idx <= dig_idx + 3'd1;
                    end
                end
                SEND_SEP: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        col      <= col + 3'd1;
                        rd_addr  <= rd_addr + 8'd1;
                        state    <= FETCH;
                    end
                end
                SEND_EOL_CR: begin
                    if (tx_valid && tx_ready) state <= SEND_EOL_LF;
                end
                SEND_EOL_LF: begin
                    if (!lf_sent) begin
                        if (tx_valid && tx_ready) begin
                            tx_valid <= 1'b0;
                            if (row == m_q - 3'd1) begin
                                lf_sent <= 1'b1;
                            end else begin
                                row     <= row + 3'd1;
                                col     <= '0;
                                rd_addr <= rd_addr + 8'd1;
                                state   <= FETCH;
                            end
                        end
                    end else if (tx_ready) begin
                        // Serializer back in idle: the final stop bit is complete.
                        lf_sent <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (tx_byte),
        .i_valid(tx_valid),
        .o_ready(tx_ready),
        .o_tx   (o_uart_tx)
    );

endmodule
